// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver (LSB first).
//   clk, rst_n   : system clock, async active-low reset
//   os_tick      : one-clk strobe at OVERSAMPLE x baud
//   rx           : async serial line, idle high
//   rx_data/rx_valid/rx_ready : holding register with valid/ready handshake
//   frame_err    : 1-clk pulse when the stop bit samples low
//   overrun      : 1-clk pulse when a good frame finds the holder still full
//   rx_busy      : receiver not idle
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 os_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  // Two-flop synchronizer; resets to the idle-high line level so reset
  // release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // Handshake runs every clk; a store below on the same edge wins.
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: if (os_tick && !rx_s_q) begin
        state_d    = S_START;
        tick_cnt_d = '0;
      end
      S_START: if (os_tick) begin
        if (tick_cnt_q == HALF_M1) begin
          // Mid start bit: still low means a real frame, else a glitch.
          if (!rx_s_q) begin
            state_d    = S_DATA;
            tick_cnt_d = '0;
            bit_idx_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      S_DATA: if (os_tick) begin
        if (tick_cnt_q == FULL_M1) begin
          shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
          tick_cnt_d = '0;
          bit_idx_d  = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_BIT) state_d = S_STOP;
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      S_STOP: if (os_tick) begin
        if (tick_cnt_q == FULL_M1) begin
          tick_cnt_d = '0;
          if (rx_s_q) begin
            // Holder is free if empty or being drained on this very edge.
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      // Park until the line returns high so a held break flags only once.
      S_BREAK: if (os_tick && rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx (DATA_BITS=8, OVERSAMPLE=16).
// A serial-line model drives rx one bit per 16 os_ticks; expected bytes are
// queued when a good frame is sent and popped when the DUT hands one over.
module tb_uart_rx;
  localparam int OS     = 16;
  localparam int OS_DIV = 4;   // clk cycles per os_tick

  logic       clk, rst_n, os_tick, rx, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, rx_busy;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    int div;
    div = 0;
    os_tick = 1'b0;
    forever begin
      @(negedge clk);
      os_tick = (div == OS_DIV-1);
      div = (div + 1) % OS_DIV;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int ferr_cnt, ovr_cnt, acc_cnt;
  bit bb_mon;
  int low_run, max_low;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor samples just after negedge; inputs change at negedge and the DUT
  // only at posedge, so the sample equals what the next posedge sees.
  initial begin
    logic v_p, r_p;
    logic [7:0] d_p;
    logic [31:0] e;
    v_p = 1'b0; r_p = 1'b0; d_p = '0;
    forever begin
      @(negedge clk); #1;
      if (rst_n && v_p && r_p) begin
        e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
        chk("rx_data", 32'(d_p), e);
        acc_cnt++;
      end
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      if (bb_mon) begin
        if (!rx_busy) low_run++;
        else begin
          if (low_run > max_low) max_low = low_run;
          low_run = 0;
        end
      end
      v_p = rx_valid; r_p = rx_ready; d_p = rx_data;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!os_tick) @(posedge clk);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx = b;
    wait_ticks(OS);
  endtask

  // Drives the first nbits of {stop, data, start} in line order.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int nbits);
    logic [9:0] fb;
    fb = {stop_b, d, 1'b0};
    for (int i = 0; i < nbits; i++) drive_bit(fb[i]);
  endtask

  task automatic send_good(input logic [7:0] d, input bit expect_it);
    if (expect_it) exp_q.push_back(d);
    send_frame(d, 1'b1, 10);
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 0);
  endtask

  task automatic clr_cnt();
    ferr_cnt = 0; ovr_cnt = 0; acc_cnt = 0;
  endtask

  initial begin
    rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b0;
    bb_mon = 1'b0; low_run = 0; max_low = 0;
    clr_cnt();
    repeat (5) @(negedge clk);
    #1;
    chk("reset_outs", 32'({rx_data, rx_valid, frame_err, overrun, rx_busy}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(20);

    // 1: single frame
    clr_cnt();
    rx_ready = 1'b1;
    send_good(8'hA5, 1'b1);
    wait_drain(400);
    chk("t1_acc", 32'(acc_cnt), 1);
    chk("t1_ferr", 32'(ferr_cnt), 0);
    chk("t1_ovr", 32'(ovr_cnt), 0);
    wait_ticks(16);

    // 2: back-to-back frames, no idle gap
    clr_cnt();
    low_run = 0; max_low = 0; bb_mon = 1'b1;
    send_good(8'h00, 1'b1);
    send_good(8'hFF, 1'b1);
    send_good(8'h3C, 1'b1);
    bb_mon = 1'b0;
    wait_drain(400);
    chk("t2_acc", 32'(acc_cnt), 3);
    chk("t2_ferr", 32'(ferr_cnt), 0);
    chk("t2_ovr", 32'(ovr_cnt), 0);
    chk("t2_busy_gap_ok", 32'(max_low <= OS*OS_DIV), 1);
    wait_ticks(16);

    // 3: start-bit glitch
    clr_cnt();
    @(negedge clk); rx = 1'b0;
    wait_ticks(4);
    @(negedge clk); rx = 1'b1;
    wait_ticks(12);
    @(negedge clk); #1;
    chk("t3_busy", 32'(rx_busy), 0);
    chk("t3_valid", 32'(rx_valid), 0);
    chk("t3_ferr", 32'(ferr_cnt), 0);
    wait_ticks(16);

    // 4: framing error followed by held-low break, then a good frame
    clr_cnt();
    send_frame(8'h55, 1'b0, 10);
    wait_ticks(3*OS);
    @(negedge clk); rx = 1'b1;
    wait_ticks(OS);
    chk("t4_ferr", 32'(ferr_cnt), 1);
    chk("t4_valid", 32'(rx_valid), 0);
    send_good(8'h12, 1'b1);
    wait_drain(400);
    chk("t4_acc", 32'(acc_cnt), 1);
    chk("t4_ferr_after", 32'(ferr_cnt), 1);
    wait_ticks(16);

    // 5: overrun with consumer stalled
    clr_cnt();
    @(negedge clk); rx_ready = 1'b0;
    send_good(8'h11, 1'b1);
    send_good(8'h22, 1'b0);
    @(negedge clk); #1;
    chk("t5_valid", 32'(rx_valid), 1);
    chk("t5_data", 32'(rx_data), 32'h11);
    chk("t5_ovr", 32'(ovr_cnt), 1);
    @(negedge clk); rx_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_valid_clr", 32'(rx_valid), 0);
    wait_drain(50);
    chk("t5_acc", 32'(acc_cnt), 1);
    wait_ticks(16);

    // 6: reset during bit 3 of 0x96, then a clean 0x69
    clr_cnt();
    send_frame(8'h96, 1'b1, 4);           // start + bits 0..2
    @(negedge clk); rx = 1'b0;            // bit 3 of 0x96
    wait_ticks(OS/2);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", 32'({rx_data, rx_valid, frame_err, overrun, rx_busy}), 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(2*OS);
    chk("t6_acc_none", 32'(acc_cnt), 0);
    send_good(8'h69, 1'b1);
    wait_drain(400);
    chk("t6_acc", 32'(acc_cnt), 1);
    chk("t6_ferr", 32'(ferr_cnt), 0);
    wait_ticks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: sim time exceeded bound");
    $fatal(1, "timeout");
  end
endmodule
